// File: rtl/mem_sched_if.sv
// Bus bundle between the memory scheduler, the two caches and main memory.
// master = scheduler side, slave = caches/memory side.
interface mem_sched_if;
  logic        ic_miss_req;
  logic [15:0] ic_miss_addr;
  logic        dc_miss_req;
  logic [15:0] dc_miss_addr;
  logic        wr_req;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic [15:0] ic_fill_addr, dc_fill_addr;
  logic [15:0] ic_fill_data, dc_fill_data;
  logic        ic_write_data, dc_write_data;
  logic        ic_write_tag, dc_write_tag;
  logic        ic_busy, dc_busy;
  logic        stall;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_rdata;
  logic        mem_valid;

  modport master (
    input  ic_miss_req, ic_miss_addr, dc_miss_req, dc_miss_addr,
           wr_req, wr_addr, wr_data, mem_rdata, mem_valid,
    output wr_ack, ic_fill_addr, dc_fill_addr, ic_fill_data, dc_fill_data,
           ic_write_data, dc_write_data, ic_write_tag, dc_write_tag,
           ic_busy, dc_busy, stall, mem_addr, mem_wdata, mem_enable, mem_wr
  );

  modport slave (
    output ic_miss_req, ic_miss_addr, dc_miss_req, dc_miss_addr,
           wr_req, wr_addr, wr_data, mem_rdata, mem_valid,
    input  wr_ack, ic_fill_addr, dc_fill_addr, ic_fill_data, dc_fill_data,
           ic_write_data, dc_write_data, ic_write_tag, dc_write_tag,
           ic_busy, dc_busy, stall, mem_addr, mem_wdata, mem_enable, mem_wr
  );
endinterface

// File: rtl/mem_sched_fsm.sv
// Shares single-ported main memory between icache fills, dcache fills and
// dcache write-through stores; streams one block per fill and raises stall.
module mem_sched_fsm #(
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic         clk,
  input  logic         rst,
  mem_sched_if.master  bus
);
  typedef enum logic [1:0] {IDLE, WRITE, FILL_I, FILL_D} state_t;

  localparam logic [3:0] WPB  = 4'(WORDS_PER_BLOCK);
  localparam logic [3:0] LAST = 4'(WORDS_PER_BLOCK - 1);

  state_t      state, state_nxt;
  logic [15:0] base, base_nxt;
  logic [3:0]  issue_cnt, issue_nxt, resp_cnt, resp_nxt;
  logic        last_fill, last_nxt;   // 1: dcache served last
  logic        write_data, write_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      base      <= '0;
      issue_cnt <= '0;
      resp_cnt  <= '0;
      last_fill <= 1'b1;
    end else begin
      state     <= state_nxt;
      base      <= base_nxt;
      issue_cnt <= issue_nxt;
      resp_cnt  <= resp_nxt;
      last_fill <= last_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    base_nxt       = base;
    issue_nxt      = issue_cnt;
    resp_nxt       = resp_cnt;
    last_nxt       = last_fill;
    bus.mem_enable = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.wr_ack     = 1'b0;
    write_data     = 1'b0;
    write_tag      = 1'b0;
    case (state)
      IDLE: begin
        // stores first so a following fill sees the written word
        if (bus.wr_req) begin
          state_nxt = WRITE;
          issue_nxt = '0;
          resp_nxt  = '0;
        end else if (bus.ic_miss_req && (!bus.dc_miss_req || last_fill)) begin
          state_nxt = FILL_I;
          base_nxt  = bus.ic_miss_addr & 16'hFFF0;
          issue_nxt = '0;
          resp_nxt  = '0;
          last_nxt  = 1'b0;
        end else if (bus.dc_miss_req) begin
          state_nxt = FILL_D;
          base_nxt  = bus.dc_miss_addr & 16'hFFF0;
          issue_nxt = '0;
          resp_nxt  = '0;
          last_nxt  = 1'b1;
        end
      end
      WRITE: begin
        bus.mem_enable = 1'b1;
        bus.mem_wr     = 1'b1;
        bus.mem_addr   = bus.wr_addr;
        bus.mem_wdata  = bus.wr_data;
        bus.wr_ack     = 1'b1;
        state_nxt      = IDLE;
      end
      FILL_I, FILL_D: begin
        if (issue_cnt < WPB) begin
          bus.mem_enable = 1'b1;
          bus.mem_addr   = base + {11'b0, issue_cnt, 1'b0};
          issue_nxt      = issue_cnt + 4'd1;
        end
        if (bus.mem_valid) begin
          write_data = 1'b1;
          resp_nxt   = resp_cnt + 4'd1;
          if (resp_cnt == LAST) begin
            write_tag = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ic_busy       = (state == FILL_I);
  assign bus.dc_busy       = (state == FILL_D);
  assign bus.stall         = bus.ic_busy | bus.dc_busy | (state == WRITE);
  assign bus.ic_write_data = bus.ic_busy & write_data;
  assign bus.dc_write_data = bus.dc_busy & write_data;
  assign bus.ic_write_tag  = bus.ic_busy & write_tag;
  assign bus.dc_write_tag  = bus.dc_busy & write_tag;
  assign bus.ic_fill_addr  = base + {11'b0, resp_cnt, 1'b0};
  assign bus.dc_fill_addr  = base + {11'b0, resp_cnt, 1'b0};
  assign bus.ic_fill_data  = bus.mem_rdata;
  assign bus.dc_fill_data  = bus.mem_rdata;
endmodule

// File: tb/tb_mem_sched_fsm.sv
// Directed bench for mem_sched_fsm with a small in-order memory model.
module tb_mem_sched_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_sched_if bus();
  mem_sched_fsm #(.WORDS_PER_BLOCK(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int ack_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // memory: read data = addr ^ 5A5A, valid LAT cycles after issue (or table latencies)
  typedef struct { logic [15:0] addr; int due; } rd_t;
  rd_t q[$];
  int  mcyc = 0;
  int  last_due = 0;
  bit  var_lat = 1'b0;
  int  lat_idx = 0;
  int  lat_tab [8] = '{3, 7, 4, 9, 2, 5, 6, 3};
  localparam int LAT = 4;

  always @(posedge clk) begin
    int due;
    if (bus.mem_enable === 1'b1 && bus.mem_wr === 1'b0) begin
      due = mcyc + (var_lat ? lat_tab[lat_idx % 8] : LAT);
      if (var_lat) lat_idx++;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      q.push_back('{bus.mem_addr, due});
    end
    mcyc++;
    if (q.size() > 0 && q[0].due == mcyc) begin
      bus.mem_valid <= 1'b1;
      bus.mem_rdata <= q[0].addr ^ 16'h5A5A;
      void'(q.pop_front());
    end else begin
      bus.mem_valid <= 1'b0;
    end
  end

  task automatic reset_dut();
    rst = 1'b1;
    bus.ic_miss_req = 0; bus.dc_miss_req = 0; bus.wr_req = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", bus.stall, 0);
    chk("rst_mem_en", bus.mem_enable, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_wr_ack", bus.wr_ack, 0);
    chk("rst_busy", {bus.ic_busy, bus.dc_busy}, 0);
    chk("rst_fill_addr", {bus.ic_fill_addr, bus.dc_fill_addr}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    last_due = 0;
  endtask

  // Follows one fill to its tag write, then drops the miss request.
  task automatic wait_fill(input bit is_d, input logic [15:0] base, input int budget,
                           output int tag_cyc);
    int n = 0;
    bit done = 0;
    logic wd, tg;
    logic [15:0] fa, fd;
    tag_cyc = -1;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      wd = is_d ? bus.dc_write_data : bus.ic_write_data;
      tg = is_d ? bus.dc_write_tag  : bus.ic_write_tag;
      fa = is_d ? bus.dc_fill_addr  : bus.ic_fill_addr;
      fd = is_d ? bus.dc_fill_data  : bus.ic_fill_data;
      if (bus.wr_ack) ack_seen++;
      if (wd) begin
        chk("fill_addr", fa, base + 16'(2 * n));
        if (n == 0) chk("fill_data", fd, base ^ 16'h5A5A);
        n++;
      end
      if (tg) begin
        chk("tag_on_last", n, 8);
        tag_cyc = mcyc;
        done = 1;
      end
    end
    chk("wd_count", n, 8);
    chk("tag_seen", done, 1);
    @(posedge clk); #1;
    if (is_d) bus.dc_miss_req = 0; else bus.ic_miss_req = 0;
  endtask

  initial begin
    int t0, tg, n, nv, bad;
    bus.ic_miss_req = 0; bus.ic_miss_addr = 0;
    bus.dc_miss_req = 0; bus.dc_miss_addr = 0;
    bus.wr_req = 0; bus.wr_addr = 0; bus.wr_data = 0;

    // icache miss at 0x1234, fixed latency 4
    reset_dut();
    bus.ic_miss_req = 1; bus.ic_miss_addr = 16'h1234;
    @(negedge clk);
    chk("t1_c0_busy", bus.ic_busy, 0);
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk); #1;
      if (k == 13) bus.ic_miss_req = 0;
      @(negedge clk);
      chk($sformatf("t1_en_c%0d", k), bus.mem_enable, (k <= 8));
      chk($sformatf("t1_addr_c%0d", k), bus.mem_addr, (k <= 8) ? 16'h1230 + 16'(2*(k-1)) : 16'h0);
      chk($sformatf("t1_wd_c%0d", k), bus.ic_write_data, (k >= 5 && k <= 12));
      if (k >= 5 && k <= 12)
        chk($sformatf("t1_faddr_c%0d", k), bus.ic_fill_addr, 16'h1230 + 16'(2*(k-5)));
      if (k == 5) chk("t1_fdata", bus.ic_fill_data, 16'h486A);
      chk($sformatf("t1_tag_c%0d", k), bus.ic_write_tag, (k == 12));
      chk($sformatf("t1_busy_c%0d", k), bus.ic_busy, (k <= 12));
      chk($sformatf("t1_dbusy_c%0d", k), bus.dc_busy, 0);
    end

    // tie after reset: icache first, dcache right after
    reset_dut();
    bus.ic_miss_req = 1; bus.ic_miss_addr = 16'h2000;
    bus.dc_miss_req = 1; bus.dc_miss_addr = 16'h3008;
    @(negedge clk); t0 = mcyc;
    @(posedge clk); #1; @(negedge clk);
    chk("tie1_first", {bus.ic_busy, bus.dc_busy}, 2'b10);
    wait_fill(0, 16'h2000, 40, tg);
    chk("tie1_ic_tag_cyc", tg - t0, 12);
    @(negedge clk);
    chk("tie1_gap", bus.dc_busy, 0);
    @(posedge clk); #1; @(negedge clk);
    chk("tie1_dc_start", mcyc - t0, 14);
    chk("tie1_dc_busy", bus.dc_busy, 1);
    chk("tie1_dc_addr", bus.mem_addr, 16'h3000);
    wait_fill(1, 16'h3000, 40, tg);
    // solo icache fill leaves last_fill = I, so the next tie goes to dcache
    bus.ic_miss_req = 1; bus.ic_miss_addr = 16'h2100;
    wait_fill(0, 16'h2100, 40, tg);
    @(posedge clk); #1;
    bus.ic_miss_req = 1; bus.ic_miss_addr = 16'h2200;
    bus.dc_miss_req = 1; bus.dc_miss_addr = 16'h3300;
    @(posedge clk); #1; @(negedge clk);
    chk("tie2_first", {bus.ic_busy, bus.dc_busy}, 2'b01);
    wait_fill(1, 16'h3300, 40, tg);
    wait_fill(0, 16'h2200, 40, tg);

    // write-through beats a pending dcache miss
    reset_dut();
    bus.wr_req = 1; bus.wr_addr = 16'h00A0; bus.wr_data = 16'hBEEF;
    bus.dc_miss_req = 1; bus.dc_miss_addr = 16'h4444;
    @(negedge clk);
    chk("wr_c0_ack", bus.wr_ack, 0);
    @(posedge clk); #1; @(negedge clk);
    chk("wr_c1_ctl", {bus.mem_enable, bus.mem_wr, bus.wr_ack, bus.stall}, 4'b1111);
    chk("wr_c1_addr", bus.mem_addr, 16'h00A0);
    chk("wr_c1_wdata", bus.mem_wdata, 16'hBEEF);
    chk("wr_c1_dbusy", bus.dc_busy, 0);
    @(posedge clk); #1; bus.wr_req = 0; @(negedge clk);
    chk("wr_c2", {bus.wr_ack, bus.dc_busy, bus.stall}, 3'b000);
    @(posedge clk); #1; @(negedge clk);
    chk("wr_c3_dbusy", bus.dc_busy, 1);
    chk("wr_c3_addr", {bus.mem_wr, bus.mem_addr}, {1'b0, 16'h4440});
    wait_fill(1, 16'h4440, 40, tg);

    // store arriving mid-fill waits for the tag write
    reset_dut();
    bus.ic_miss_req = 1; bus.ic_miss_addr = 16'h5006;
    repeat (3) begin @(posedge clk); #1; end
    bus.wr_req = 1; bus.wr_addr = 16'h00A2; bus.wr_data = 16'h1111;
    ack_seen = 0;
    wait_fill(0, 16'h5000, 40, tg);
    chk("wr_held_off", ack_seen, 0);
    @(negedge clk);
    chk("wr_after_tag_ack", bus.wr_ack, 0);
    @(posedge clk); #1; @(negedge clk);
    chk("wr_late_ack", {bus.wr_ack, bus.mem_wr}, 2'b11);
    chk("wr_late_addr", bus.mem_addr, 16'h00A2);
    @(posedge clk); #1; bus.wr_req = 0;

    // reset after the third fill word
    reset_dut();
    bus.ic_miss_req = 1; bus.ic_miss_addr = 16'h6010;
    n = 0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1; @(negedge clk);
      if (bus.ic_write_data) n++;
    end
    chk("rst_pre_words", n, 3);
    @(posedge clk); #1; rst = 1; bus.ic_miss_req = 0;
    @(posedge clk); #1; rst = 0; @(negedge clk);
    chk("rst_mid_ctl", {bus.mem_enable, bus.stall, bus.ic_busy, bus.ic_write_data, bus.ic_write_tag}, 0);
    chk("rst_mid_addr", bus.mem_addr, 0);
    chk("rst_mid_faddr", bus.ic_fill_addr, 0);
    nv = 0; bad = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.mem_valid) nv++;
      if (bus.ic_write_data || bus.ic_write_tag || bus.dc_write_data || bus.dc_write_tag) bad++;
      @(negedge clk);
    end
    chk("rst_late_valids", nv, 4);
    chk("rst_late_writes", bad, 0);

    // variable memory latency
    reset_dut();
    var_lat = 1; lat_idx = 0;
    bus.dc_miss_req = 1; bus.dc_miss_addr = 16'h7ABC;
    wait_fill(1, 16'h7AB0, 80, tg);
    var_lat = 0;
    @(negedge clk);
    chk("var_done", {bus.dc_busy, bus.stall}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
